// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// The master side offers words and observes the serial stream; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_en;
    logic             busy;
    logic             done;

    modport master (
        output data_in, load_valid,
        input  load_ready, serial_out, serial_en, busy, done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, serial_out, serial_en, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: one bit per clock with a valid/ready load handshake.
// A new word may be accepted on the last-bit cycle, so frames stream with no idle gap.
module piso_serializer #(
    parameter int   WIDTH      = 4,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               serial_out_q, serial_out_d;
    logic               serial_en_q, serial_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_bit;
    logic               accept;

    assign last_bit       = (state_q == SHIFT) && (cnt_q == LAST);
    assign bus.load_ready = (state_q == IDLE) || last_bit;
    assign accept         = bus.load_valid && bus.load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            serial_out_q <= IDLE_LEVEL;
            serial_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            serial_out_q <= serial_out_d;
            serial_en_q  <= serial_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        serial_out_d = serial_out_q;
        serial_en_d  = serial_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        if (state_q == SHIFT) begin
            if (!last_bit) begin
                cnt_d        = cnt_q + CNT_W'(1);
                serial_out_d = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
                shreg_d      = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            end else begin
                done_d       = 1'b1;
                state_d      = IDLE;
                serial_en_d  = 1'b0;
                busy_d       = 1'b0;
                serial_out_d = IDLE_LEVEL;
            end
        end

        // Accept overrides the end-of-frame idle return, giving back-to-back frames.
        if (accept) begin
            state_d      = SHIFT;
            cnt_d        = '0;
            serial_out_d = LSB_FIRST ? bus.data_in[0] : bus.data_in[WIDTH-1];
            shreg_d      = LSB_FIRST ? (bus.data_in >> 1) : (bus.data_in << 1);
            serial_en_d  = 1'b1;
            busy_d       = 1'b1;
        end
    end

    assign bus.serial_out = serial_out_q;
    assign bus.serial_en  = serial_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: LSB-first 4-bit instance with a loopback right-shift register,
// plus an MSB-first 8-bit instance.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(4)) ifa ();
    piso_serializer_if #(.WIDTH(8)) ifb ();

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Loopback right-shift SISO fed from instance A
    logic [3:0] siso_q = 4'h0;
    always @(posedge clk) siso_q <= {ifa.serial_out, siso_q[3:1]};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp8;
        rst = 1'b1;
        ifa.data_in = '0; ifa.load_valid = 1'b0;
        ifb.data_in = '0; ifb.load_valid = 1'b0;

        // 1. Reset
        tick(); tick();
        chk("rst_sout", 32'(ifa.serial_out), 0);
        chk("rst_en",   32'(ifa.serial_en), 0);
        chk("rst_busy", 32'(ifa.busy), 0);
        chk("rst_done", 32'(ifa.done), 0);
        chk("rst_rdy",  32'(ifa.load_ready), 1);
        chk("rst_b_en", 32'(ifb.serial_en), 0);
        rst = 1'b0;
        tick();

        // 2. Single word 4'b1101 with loopback
        ifa.data_in = 4'b1101; ifa.load_valid = 1'b1;
        tick();
        ifa.load_valid = 1'b0; ifa.data_in = 4'h0;
        exp8 = 8'h0D;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s_bit%0d", k), 32'(ifa.serial_out), 32'(exp8[k]));
            chk($sformatf("s_en%0d", k),  32'(ifa.serial_en), 1);
            chk($sformatf("s_dn%0d", k),  32'(ifa.done), 0);
            tick();
        end
        chk("s_done", 32'(ifa.done), 1);
        chk("s_siso", 32'(siso_q), 32'hD);
        chk("s_en_off", 32'(ifa.serial_en), 0);
        chk("s_busy_off", 32'(ifa.busy), 0);
        tick();
        chk("s_done_clr", 32'(ifa.done), 0);

        // 3. Back-to-back 4'hA then 4'h5
        ifa.data_in = 4'hA; ifa.load_valid = 1'b1;
        tick();
        exp8 = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("b_bit%0d", k),  32'(ifa.serial_out), 32'(exp8[k]));
            chk($sformatf("b_en%0d", k),   32'(ifa.serial_en), 1);
            chk($sformatf("b_busy%0d", k), 32'(ifa.busy), 1);
            chk($sformatf("b_dn%0d", k),   32'(ifa.done), (k == 4) ? 1 : 0);
            if (k == 0) chk("b_rdy0", 32'(ifa.load_ready), 0);
            if (k == 3) begin
                chk("b_rdy3", 32'(ifa.load_ready), 1);
                ifa.data_in = 4'h5;
            end
            if (k == 4) ifa.load_valid = 1'b0;
            tick();
        end
        chk("b_done2", 32'(ifa.done), 1);
        chk("b_en_off", 32'(ifa.serial_en), 0);
        tick();

        // 4. Load ignored while busy
        ifa.data_in = 4'h3; ifa.load_valid = 1'b1;
        tick();
        ifa.load_valid = 1'b0;
        exp8 = 8'h03;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                ifa.data_in = 4'hF; ifa.load_valid = 1'b1;
                chk("r_rdy", 32'(ifa.load_ready), 0);
            end
            if (k == 2) ifa.load_valid = 1'b0;
            chk($sformatf("r_bit%0d", k), 32'(ifa.serial_out), 32'(exp8[k]));
            chk($sformatf("r_dn%0d", k),  32'(ifa.done), 0);
            tick();
        end
        chk("r_done", 32'(ifa.done), 1);
        tick();
        chk("r_done_clr", 32'(ifa.done), 0);
        chk("r_en_off", 32'(ifa.serial_en), 0);
        tick();
        chk("r_no_2nd", 32'(ifa.done), 0);
        chk("r_idle", 32'(ifa.busy), 0);

        // 5. Reset mid-frame on bit 2 of 4'h9
        ifa.data_in = 4'h9; ifa.load_valid = 1'b1;
        tick();
        ifa.load_valid = 1'b0;
        tick(); tick();
        chk("m_bit2", 32'(ifa.serial_out), 0);
        chk("m_busy", 32'(ifa.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("m_en",   32'(ifa.serial_en), 0);
        chk("m_busy0", 32'(ifa.busy), 0);
        chk("m_sout", 32'(ifa.serial_out), 0);
        chk("m_rdy",  32'(ifa.load_ready), 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("m_dn%0d", k), 32'(ifa.done), 0);
            tick();
        end

        // 6. MSB-first 8-bit 8'hC3
        ifb.data_in = 8'hC3; ifb.load_valid = 1'b1;
        tick();
        ifb.load_valid = 1'b0; ifb.data_in = 8'h00;
        exp8 = 8'hC3;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("f_bit%0d", k), 32'(ifb.serial_out), 32'(exp8[7-k]));
            chk($sformatf("f_en%0d", k),  32'(ifb.serial_en), 1);
            chk($sformatf("f_dn%0d", k),  32'(ifb.done), 0);
            tick();
        end
        chk("f_done", 32'(ifb.done), 1);
        chk("f_en_off", 32'(ifb.serial_en), 0);
        tick();
        chk("f_done_clr", 32'(ifb.done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready load handshake and drives it out one bit per clock on serial_out, qualified by serial_en. With the default LSB-first order, its output drives the serial_in of the team's right-shifting serial-in register (siso_Rshift). After WIDTH shifts the captured word appears unchanged in that register's q. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, word length in bits; legal range 2..32.
LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.
IDLE_LEVEL, 0, value driven on serial_out when no bit is being sent.

Ports:
clk  input  1  rising-edge clock; the only clock domain.
rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
data_in  input  WIDTH  word to transmit; sampled only on the accept edge.
load_valid  input  1  a word is offered on data_in.
load_ready  output  1  block can accept a word this cycle (combinational).
serial_out  output  1  serial data bit (registered).
serial_en  output  1  high while serial_out carries a valid bit (registered).
busy  output  1  a frame is in progress (registered).
done  output  1  one-cycle pulse after the last bit of a frame (registered).

Behaviour:
- Reset (rst=1 at an edge), taking priority over everything else:
  - state=IDLE, bit counter=0, shift register=0.
  - serial_out=IDLE_LEVEL, serial_en=0, busy=0, done=0.
- States:
  - IDLE: load_ready=1.
  - SHIFT: load_ready=1 only when the counter is at WIDTH-1 (last-bit cycle); otherwise 0.
- Accept: an edge where load_valid and load_ready are both high. Call it E0.
  - At E0: the word is captured; serial_out <= first bit (data_in[0] if LSB_FIRST, else data_in[WIDTH-1]).
  - Also at E0: serial_en<=1, busy<=1, counter<=0, state<=SHIFT.
  - The remaining bits are held in the shift register. data_in need not stay stable after E0.
- SHIFT, each edge:
  - If counter < WIDTH-1: counter++ and serial_out <= next bit in the selected order.
  - As a result, bit k is on serial_out during the cycle following edge E0+k, for k=0..WIDTH-1.
- End of frame, at edge E0+WIDTH:
  - done<=1 for exactly one cycle.
  - If there is no new accept at that edge: state<=IDLE, serial_en<=0, busy<=0, serial_out<=IDLE_LEVEL.
  - If there is a simultaneous accept (back-to-back): the new word's first bit is loaded, serial_en and busy stay 1, and done still pulses.
- Ignored loads: load_valid while load_ready=0 causes no capture and does not disturb the current frame.
- Reset mid-frame: the frame is aborted and all outputs go to their reset values on the next edge. No done pulse is issued for the aborted frame.
- Latency: accept to first valid bit = 1 edge. Accept to done = WIDTH+1 edges. Sustained throughput = 1 bit per clock.
- Loopback: a right-shift SISO clocked by clk, with serial_in=serial_out and LSB_FIRST=1, holds the accepted word in q after edge E0+WIDTH.

Test Plan:
1. Reset: hold rst=1 for 2 cycles, load_valid=0 -> serial_out=0, serial_en=0, busy=0, done=0, load_ready=1.
2. Single word, WIDTH=4, data_in=4'b1101, one-cycle load_valid:
   - serial_out = 1,0,1,1 on the 4 cycles after E0 with serial_en=1.
   - done=1 in cycle E0+4.
   - Loopback SISO q=4'b1101 at that point.
3. Back-to-back: 4'hA then 4'h5, with load_valid held and data switched on the last-bit cycle:
   - 8 consecutive serial_en=1 cycles carrying 0,1,0,1,1,0,1,0.
   - busy never drops; done pulses at E0+4 and E0+8.
4. Busy rejection: during bit 1 of 4'h3, pulse load_valid with 4'hF -> load_ready=0, stream stays 1,1,0,0, only one done pulse.
5. Reset mid-frame: rst=1 during bit 2 of 4'h9 -> the next cycle has serial_en=0, busy=0, serial_out=0, load_ready=1, and done never pulses.
6. MSB-first: LSB_FIRST=0, WIDTH=8, data_in=8'hC3 -> serial_out = 1,1,0,0,0,0,1,1, then done at E0+8.
